pb_grant_scheduler: RTL and testbench

- Shares one manually stepped datapath between N push-button requesters.
- Each button passes through a per-channel one-pulse stage; presses latch as pending requests.
- A round-robin FSM issues one-cycle start/grant pulses, then waits for the datapath's done signal or a timeout.
- Sits between board push-buttons and the lab datapath's clock-enable/start input.

---
 rtl/pb_grant_scheduler_pkg.sv | 14 +
 rtl/pb_grant_scheduler_edge.sv | 32 +++
 rtl/pb_grant_scheduler.sv | 104 ++++++++++
 tb/tb_pb_grant_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pb_grant_scheduler_pkg.sv
// Shared encodings for the push-button grant scheduler and its edge stages.
package pb_grant_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    localparam logic [1:0] EDGE_LOW  = 2'b00;
    localparam logic [1:0] EDGE_HIT  = 2'b01;
    localparam logic [1:0] EDGE_HELD = 2'b10;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/pb_grant_scheduler_edge.sv
// Single-channel one-pulse stage: one HIT cycle per press, however long the button is held.
// state | meaning
// LOW   | button released, armed for the next press
// HIT   | first cycle of a press, pulse high
// HELD  | button still down, waiting for release
module pb_edge_stage
    import pb_grant_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic pulse
);

    logic [1:0] state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EDGE_LOW;
        end else begin
            case (state)
                EDGE_LOW:  if (pb) state <= EDGE_HIT;
                EDGE_HIT:  state <= EDGE_HELD;
                EDGE_HELD: if (!pb) state <= EDGE_LOW;
                default:   state <= EDGE_LOW;
            endcase
        end
    end

    assign pulse = (state == EDGE_HIT);

endmodule

// File: rtl/pb_grant_scheduler.sv
// Round-robin scheduler sharing one stepped datapath between N push-button requesters.
// state | meaning
// IDLE  | no grant in flight; picks the next pending requester
// ISSUE | one-cycle dp_start/grant pulse for the registered winner
// WAIT  | waiting for dp_done or the wait-counter timeout
module pb_grant_scheduler
    import pb_grant_scheduler_pkg::*;
#(
    parameter int N        = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pb,
    input  logic         dp_done,
    output logic         dp_start,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [N-1:0] pending,
    output logic         timeout_err
);

    localparam int IW = $clog2(N);
    localparam logic [WAIT_CNT_W-1:0] WAIT_TERM = WAIT_CNT_W'(WAIT_MAX - 1);

    logic [1:0]            state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         winner;
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic [N-1:0]          pulse;
    logic [N-1:0]          winnerHot;
    logic [N-1:0]          clrMask;

    // First set bit scanning upward from start, wrapping modulo N; the downward
    // loop lets the smallest offset overwrite the others.
    function automatic logic [IW-1:0] rrPick(input logic [N-1:0] req, input logic [IW-1:0] start);
        logic [IW-1:0] pick;
        int idx;
        pick = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (req[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    for (genvar i = 0; i < N; i++) begin : gEdge
        pb_edge_stage uEdge (
            .clk   (clk),
            .rst   (rst),
            .pb    (pb[i]),
            .pulse (pulse[i])
        );
    end

    assign winnerHot = N'(1) << winner;
    assign clrMask   = (state == ST_ISSUE) ? winnerHot : '0;

    // A new press on the bit being cleared wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clrMask) | pulse;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            winner  <= '0;
            waitCnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        winner <= rrPick(pending, ptr);
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ptr     <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
                    waitCnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dp_done || waitCnt == WAIT_TERM) begin
                        state <= ST_IDLE;
                    end else begin
                        waitCnt <= waitCnt + WAIT_CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dp_start    = (state == ST_ISSUE);
    assign grant       = dp_start ? winnerHot : '0;
    assign busy        = (state == ST_ISSUE) || (state == ST_WAIT);
    assign timeout_err = (state == ST_WAIT) && (waitCnt == WAIT_TERM) && !dp_done;

endmodule

// File: tb/tb_pb_grant_scheduler.sv
// Directed bench for pb_grant_scheduler (N=4, WAIT_MAX=5) with hand-computed expectations.
module tb_pb_grant_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pb;
    logic       dp_done;
    logic       dp_start;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] pending;
    logic       timeout_err;

    int nChecks = 0;
    int nPass   = 0;
    int startCnt = 0;
    int toCnt    = 0;
    logic [3:0] lastGrant = '0;

    pb_grant_scheduler #(.N(4), .WAIT_MAX(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .pb          (pb),
        .dp_done     (dp_done),
        .dp_start    (dp_start),
        .grant       (grant),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Event monitor samples mid low-phase, after the bench drives its inputs.
    always begin
        @(negedge clk);
        #2;
        if (dp_start === 1'b1) begin
            startCnt++;
            lastGrant = grant;
        end
        if (timeout_err === 1'b1) toCnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic doReset();
        rst = 1'b1;
        pb = '0;
        dp_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitStart(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (dp_start) return;
        end
        cyc = -1;
    endtask

    // Waits for a start, then gives dp_done for the single WAIT cycle that follows.
    task automatic serveOne(output int cyc, output logic [3:0] g);
        waitStart(cyc);
        g = grant;
        if (cyc < 0) return;
        @(negedge clk);
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
    endtask

    initial begin
        int cyc;
        int n;
        int s0;
        int t0;
        logic [3:0] g;

        rst = 1'b1;
        pb = '0;
        dp_done = 1'b0;
        #1;
        check("reset_outs", {busy, dp_start, grant, pending, timeout_err}, '0);

        // Async reset mid-WAIT with two requests pending
        doReset();
        pb = 4'b0001;
        waitStart(cyc);
        check("t1_start_lat", cyc, 3);
        pb = 4'b0111;
        @(negedge clk);
        @(negedge clk);
        check("t1_pending", pending, 4'b0110);
        check("t1_busy", busy, 1);
        #3 rst = 1'b1;
        #1 check("t1_async_rst", {busy, dp_start, grant, pending, timeout_err}, '0);
        pb = '0;
        @(negedge clk);
        rst = 1'b0;
        s0 = startCnt;
        repeat (8) @(negedge clk);
        check("t1_no_phantom", startCnt - s0, 0);

        // Single long press
        s0 = startCnt;
        pb = 4'b0100;
        serveOne(cyc, g);
        check("t2_lat", cyc, 3);
        check("t2_grant", g, 4'b0100);
        repeat (5) @(negedge clk);
        pb = '0;
        repeat (4) @(negedge clk);
        check("t2_one_start", startCnt - s0, 1);
        check("t2_pending", pending, 4'b0000);
        check("t2_idle", busy, 0);

        // Simultaneous presses served round-robin, then pointer wrap
        doReset();
        pb = 4'b1011;
        serveOne(cyc, g);
        check("t3_lat0", cyc, 3);
        check("t3_grant0", g, 4'b0001);
        serveOne(cyc, g);
        check("t3_gap1", cyc, 1);
        check("t3_grant1", g, 4'b0010);
        serveOne(cyc, g);
        check("t3_gap3", cyc, 1);
        check("t3_grant3", g, 4'b1000);
        check("t3_pending", pending, 4'b0000);
        pb = '0;
        repeat (2) @(negedge clk);
        pb = 4'b0011;
        serveOne(cyc, g);
        check("t3_wrap_lat", cyc, 3);
        check("t3_wrap_g0", g, 4'b0001);
        serveOne(cyc, g);
        check("t3_wrap_gap", cyc, 1);
        check("t3_wrap_g1", g, 4'b0010);
        pb = '0;
        repeat (2) @(negedge clk);

        // Duplicate press of pb[1] while pb[0] is in WAIT
        doReset();
        pb = 4'b0001;
        waitStart(cyc);
        check("t4_grant0", grant, 4'b0001);
        pb = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        check("t4_pend_first", pending, 4'b0010);
        pb = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        pb = 4'b0011;
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        check("t4_pend_idle", pending, 4'b0010);
        check("t4_not_busy", busy, 0);
        pb = 4'b0001;
        s0 = startCnt;
        repeat (12) @(negedge clk);
        check("t4_one_grant", startCnt - s0, 1);
        check("t4_grant1", lastGrant, 4'b0010);
        check("t4_pending", pending, 4'b0000);

        // Timeout on pb[3]; pb[0] pressed during WAIT is served next
        pb = '0;
        @(negedge clk);
        t0 = toCnt;
        pb = 4'b1000;
        waitStart(cyc);
        check("t5_lat", cyc, 3);
        check("t5_grant3", grant, 4'b1000);
        pb = 4'b1001;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (timeout_err) break;
        end
        check("t5_to_cycles", n, 5);
        check("t5_busy_at_to", busy, 1);
        @(negedge clk);
        check("t5_idle", busy, 0);
        check("t5_one_pulse", toCnt - t0, 1);
        serveOne(cyc, g);
        check("t5_next_gap", cyc, 1);
        check("t5_next_grant", g, 4'b0001);

        // dp_done on the exact timeout cycle
        pb = '0;
        @(negedge clk);
        pb = 4'b0100;
        waitStart(cyc);
        check("t6_grant2", grant, 4'b0100);
        t0 = toCnt;
        repeat (4) @(negedge clk);
        check("t6_pre_tie", timeout_err, 0);
        @(negedge clk);
        dp_done = 1'b1;
        #1;
        check("t6_tie_no_err", timeout_err, 0);
        check("t6_tie_busy", busy, 1);
        @(negedge clk);
        dp_done = 1'b0;
        check("t6_idle", busy, 0);
        check("t6_no_pulse", toCnt - t0, 0);
        pb = '0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
